// File: rtl/rosc_line_bank.sv
// Bank of independent noise-dithered Bresenham line channels with a two-state
// configuration port that reprograms one channel at a time.
module rosc_line_bank #(
    parameter int NCH = 4,
    parameter int DW  = 16,
    parameter int NW  = 4,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [DW-1:0]     cfg_deltax,
    input  logic [DW-1:0]     cfg_deltay,
    input  logic              cfg_mode,
    input  logic [NCH*NW-1:0] noise,
    output logic [NCH-1:0]    out,
    output logic [NCH-1:0]    ev
);

    // Accumulator is wide enough for dx + dy + noise headroom; it wraps in two's complement.
    localparam int AW = DW + NW + 3;

    typedef enum logic {
        ST_IDLE,
        ST_APPLY
    } cfg_state_t;

    cfg_state_t state_reg, state_next;

    logic          capture_en;
    logic          apply_active;
    logic [CW-1:0] cap_ch_reg;
    logic [DW-1:0] cap_dx_reg;
    logic [DW-1:0] cap_dy_reg;
    logic          cap_mode_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cfg_ready    = 1'b0;
        capture_en   = 1'b0;
        apply_active = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    capture_en = 1'b1;
                    state_next = ST_APPLY;
                end
            end
            ST_APPLY: begin
                apply_active = 1'b1;
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_ch_reg   <= '0;
            cap_dx_reg   <= '0;
            cap_dy_reg   <= '0;
            cap_mode_reg <= 1'b0;
        end else if (capture_en) begin
            cap_ch_reg   <= cfg_ch;
            cap_dx_reg   <= cfg_deltax;
            cap_dy_reg   <= cfg_deltay;
            cap_mode_reg <= cfg_mode;
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DW-1:0]        dx_reg;
            logic [DW-1:0]        dy_reg;
            logic                 mode_reg;
            logic signed [AW-1:0] err_reg;
            logic signed [AW-1:0] err_next;
            logic                 out_reg;
            logic                 out_next;
            logic                 ev_reg;
            logic                 ev_next;
            logic signed [AW-1:0] dx_e;
            logic signed [AW-1:0] dy_e;
            logic signed [AW-1:0] nz_e;
            logic                 steep;
            logic                 idle;
            logic                 event_hit;
            logic                 hit;

            // Out-of-range channel indices never match any gi, so such writes vanish.
            assign hit = apply_active && (cap_ch_reg == CW'(gi));

            always_comb begin
                dx_e      = $signed({{(AW-DW){1'b0}}, dx_reg});
                dy_e      = $signed({{(AW-DW){1'b0}}, dy_reg});
                nz_e      = $signed({{(AW-NW){1'b0}}, noise[gi*NW +: NW]});
                steep     = (dy_reg > dx_reg);
                idle      = (dx_reg == '0) && (dy_reg == '0);
                event_hit = 1'b0;
                err_next  = err_reg;
                out_next  = mode_reg ? 1'b0 : out_reg;
                ev_next   = 1'b0;
                if (idle) begin
                    err_next = '0;
                    out_next = 1'b0;
                end else if (enb) begin
                    if (steep) begin
                        if (err_reg < dx_e) begin
                            err_next  = err_reg + dy_e - dx_e + nz_e;
                            event_hit = 1'b1;
                        end else begin
                            err_next = err_reg + dy_e - dx_e - dx_e + nz_e;
                        end
                    end else begin
                        if (err_reg < dy_e) begin
                            err_next  = err_reg + dx_e - dy_e + nz_e;
                            event_hit = 1'b1;
                        end else begin
                            err_next = err_reg + nz_e - dy_e;
                        end
                    end
                    if (event_hit) begin
                        out_next = mode_reg ? 1'b1 : ~out_reg;
                        ev_next  = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dx_reg   <= '0;
                    dy_reg   <= '0;
                    mode_reg <= 1'b0;
                    err_reg  <= '0;
                    out_reg  <= 1'b0;
                    ev_reg   <= 1'b0;
                end else if (hit) begin
                    dx_reg   <= cap_dx_reg;
                    dy_reg   <= cap_dy_reg;
                    mode_reg <= cap_mode_reg;
                    err_reg  <= '0;
                    out_reg  <= 1'b0;
                    ev_reg   <= 1'b0;
                end else begin
                    err_reg <= err_next;
                    out_reg <= out_next;
                    ev_reg  <= ev_next;
                end
            end

            assign out[gi] = out_reg;
            assign ev[gi]  = ev_reg;
        end
    endgenerate

endmodule

// File: tb/tb_rosc_line_bank.sv
// Scoreboard bench for rosc_line_bank: a behavioural model pushes expected
// out/ev/cfg_ready per cycle, compared one cycle later against the DUT.
module tb_rosc_line_bank;

    localparam int NCH = 3;
    localparam int DW  = 16;
    localparam int NW  = 4;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              enb;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CW-1:0]     cfg_ch;
    logic [DW-1:0]     cfg_deltax;
    logic [DW-1:0]     cfg_deltay;
    logic              cfg_mode;
    logic [NCH*NW-1:0] noise;
    logic [NCH-1:0]    out;
    logic [NCH-1:0]    ev;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int             m_dx [NCH];
    int             m_dy [NCH];
    int             m_err[NCH];
    logic [NCH-1:0] m_mode;
    logic [NCH-1:0] m_out;
    logic [NCH-1:0] m_ev;
    int             m_state;
    int             m_cap_ch, m_cap_dx, m_cap_dy;
    logic           m_cap_mode;

    logic [2*NCH:0] exp_q[$];

    rosc_line_bank #(.NCH(NCH), .DW(DW), .NW(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_deltax(cfg_deltax),
        .cfg_deltay(cfg_deltay),
        .cfg_mode  (cfg_mode),
        .noise     (noise),
        .out       (out),
        .ev        (ev)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int c = 0; c < NCH; c++) begin
            m_dx[c] = 0; m_dy[c] = 0; m_err[c] = 0;
        end
        m_mode = '0; m_out = '0; m_ev = '0; m_state = 0;
    endtask

    task automatic advance(input int c);
        int  n;
        bit  e;
        n = int'(noise[c*NW +: NW]);
        e = 0;
        if (m_dx[c] == 0 && m_dy[c] == 0) begin
            m_err[c] = 0; m_out[c] = 1'b0; m_ev[c] = 1'b0;
        end else if (!enb) begin
            m_ev[c] = 1'b0;
            if (m_mode[c]) m_out[c] = 1'b0;
        end else begin
            if (m_dy[c] > m_dx[c]) begin
                if (m_err[c] < m_dx[c]) begin
                    m_err[c] = m_err[c] + m_dy[c] - m_dx[c] + n; e = 1;
                end else begin
                    m_err[c] = m_err[c] + m_dy[c] - 2 * m_dx[c] + n;
                end
            end else begin
                if (m_err[c] < m_dy[c]) begin
                    m_err[c] = m_err[c] + m_dx[c] - m_dy[c] + n; e = 1;
                end else begin
                    m_err[c] = m_err[c] + n - m_dy[c];
                end
            end
            m_ev[c] = e;
            if (m_mode[c]) m_out[c] = e;
            else if (e) m_out[c] = ~m_out[c];
        end
    endtask

    // One clock: model update from current inputs, push, clock, pop and compare.
    task automatic step();
        logic [2*NCH:0] exp_v;
        for (int c = 0; c < NCH; c++) begin
            if (m_state == 1 && m_cap_ch == c) begin
                m_dx[c] = m_cap_dx; m_dy[c] = m_cap_dy; m_mode[c] = m_cap_mode;
                m_err[c] = 0; m_out[c] = 1'b0; m_ev[c] = 1'b0;
            end else begin
                advance(c);
            end
        end
        if (m_state == 0 && cfg_valid) begin
            m_cap_ch = int'(cfg_ch); m_cap_dx = int'(cfg_deltax);
            m_cap_dy = int'(cfg_deltay); m_cap_mode = cfg_mode;
            m_state = 1;
        end else begin
            m_state = 0;
        end
        exp_q.push_back({(m_state == 0), m_out, m_ev});
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        check("out", 32'(out), 32'(exp_v[2*NCH-1:NCH]));
        check("ev", 32'(ev), 32'(exp_v[NCH-1:0]));
        check("cfg_ready", 32'(cfg_ready), 32'(exp_v[2*NCH]));
    endtask

    task automatic cfg_write(input int ch, input int dx, input int dy, input logic mode);
        cfg_valid  = 1'b1;
        cfg_ch     = CW'(ch);
        cfg_deltax = DW'(dx);
        cfg_deltay = DW'(dy);
        cfg_mode   = mode;
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    initial begin
        logic [8:0] h_ev0, h_out0, h_ev1, h_out1;
        int         cnt;
        rst = 1'b1; enb = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
        cfg_deltax = '0; cfg_deltay = '0; cfg_mode = 1'b0; noise = '0;
        reset_model();
        #3;
        check("rst_out", 32'(out), 32'h0);
        check("rst_ev", 32'(ev), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // Program ch0 (shallow, toggle) and ch1 (steep, pulse) while halted.
        cfg_write(0, 3, 1, 1'b0);
        cfg_write(1, 2, 3, 1'b1);
        step();

        enb = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            h_ev0[k] = ev[0]; h_out0[k] = out[0];
            h_ev1[k] = ev[1]; h_out1[k] = out[1];
        end
        check("ch0_ev_pattern", 32'(h_ev0), 32'h049);
        check("ch0_out_pattern", 32'(h_out0), 32'h1c7);
        check("ch1_ev_pattern", 32'(h_ev1), 32'h0ab);
        check("ch1_out_pattern", 32'(h_out1), 32'h0ab);

        // Halted: toggle out holds, pulse out and strobes drop.
        enb = 1'b0;
        step();
        step();
        enb = 1'b1;

        // Reconfigure ch0 mid-run; ch1 keeps going.
        cfg_write(0, 5, 2, 1'b0);
        for (int k = 0; k < 6; k++) step();

        // Out-of-range target, valid held into APPLY so the second beat is dropped.
        cfg_valid  = 1'b1;
        cfg_ch     = CW'(NCH);
        cfg_deltax = 16'd7;
        cfg_deltay = 16'd7;
        cfg_mode   = 1'b1;
        step();
        cfg_ch = '0;
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();

        // Constant noise on ch2 saturates the error after the first event.
        noise = {4'h1, 8'h00};
        cfg_write(2, 3, 1, 1'b0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            cnt += int'(ev[2]);
        end
        check("ch2_ev_count", 32'(cnt), 32'd1);
        check("ch2_out_hold", 32'(out[2]), 32'h1);

        // Asynchronous reset landing in APPLY.
        cfg_valid = 1'b1;
        cfg_ch = 2'd1; cfg_deltax = 16'd4; cfg_deltay = 16'd9; cfg_mode = 1'b0;
        step();
        cfg_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_out", 32'(out), 32'h0);
        check("arst_ev", 32'(ev), 32'h0);
        check("arst_ready", 32'(cfg_ready), 32'h1);
        reset_model();
        #3;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
